// File: rtl/arb_pkg.sv
// Shared constants and sizing helpers for the round-robin request/grant arbiter.
package arb_pkg;

  localparam int unsigned N_DEF   = 4;
  localparam int unsigned IDW_DEF = $clog2(N_DEF);

  // Longest legal request-to-grant latency in cycles.
  function automatic int unsigned wait_max(input int unsigned n);
    return n + 1;
  endfunction

  // Wide enough to hold wait_max+1, so an overrun stays visible at saturation.
  function automatic int unsigned wait_cnt_w(input int unsigned n);
    return $clog2(n + 3);
  endfunction

  localparam int unsigned WAIT_MAX = wait_max(N_DEF);
  localparam int unsigned WAIT_CW  = wait_cnt_w(N_DEF);

endpackage

// File: rtl/rr_req_gnt_arbiter_pick.sv
// Round-robin pick: rotate pend so ptr lands at bit 0, take the lowest set bit, rotate back.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   pend,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] pick_id
);

  logic [N-1:0]   rot;
  logic [IDW-1:0] off;
  logic           found;

  always_comb begin
    rot   = '0;
    off   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      rot[k] = pend[IDW'(k) + ptr];
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IDW'(k);
      end
    end
    pick    = '0;
    pick_id = '0;
    // N is a power of two, so the IDW-bit add wraps modulo N for free.
    if (found) begin
      pick_id       = off + ptr;
      pick[pick_id] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin arbiter: level req in, one-cycle registered one-hot gnt out, sticky latency monitor.
module rr_req_gnt_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id,
  output logic           lat_err
);

  localparam int unsigned WMAX = wait_max(N);
  localparam int unsigned CW   = wait_cnt_w(N);

  logic [N-1:0]   pend_q, pend_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_q;
  logic           gnt_vld_q;
  logic [IDW-1:0] gnt_id_q;
  logic           lat_err_q, lat_err_d;
  logic [CW-1:0]  cnt_q [N];
  logic [CW-1:0]  cnt_d [N];

  logic [N-1:0]   pick;
  logic [IDW-1:0] pick_id;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .pend    (pend_q),
    .ptr     (ptr_q),
    .pick    (pick),
    .pick_id (pick_id)
  );

  always_comb begin
    // Masking with gnt_q stops the request still held on its grant edge being re-captured.
    pend_d = req & ~pick & ~gnt_q;
    ptr_d  = ptr_q;
    if (|pick) begin
      ptr_d = pick_id + IDW'(1);
    end
    lat_err_d = lat_err_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (!req[i] || gnt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      if (cnt_q[i] > CW'(WMAX)) begin
        lat_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_id_q  <= '0;
      lat_err_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      gnt_q     <= pick;
      gnt_vld_q <= |pick;
      gnt_id_q  <= pick_id;
      lat_err_q <= lat_err_d;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_id  = gnt_id_q;
  assign lat_err = lat_err_q;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Bench for rr_req_gnt_arbiter: directed vector table plus protocol-following random traffic.
module tb_rr_req_gnt_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned WMAX = N + 1;
  localparam int unsigned NV   = 32;
  localparam int unsigned NRND = 10000;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic           lat_err;

  always #5 clk = ~clk;

  rr_req_gnt_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id),
    .lat_err (lat_err)
  );

  typedef struct {
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
  } vec_t;

  typedef struct {
    int unsigned    idx;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic setv(input int unsigned k, input logic r, input logic [N-1:0] rq,
                      input logic [N-1:0] g, input logic [IDW-1:0] id);
    vecs[k].rst = r;
    vecs[k].req = rq;
    vecs[k].gnt = g;
    vecs[k].id  = id;
  endtask

  function automatic logic [IDW-1:0] enc(input logic [N-1:0] v);
    for (int unsigned k = 0; k < N; k++) begin
      if (v[k]) return IDW'(k);
    end
    return '0;
  endfunction

  logic [N-1:0] g;
  int unsigned  age [N];
  bit           outst [N];
  bit           hold [N];
  exp_t         e;

  initial begin
    // Expected gnt/gnt_id are the values visible just after the edge that samples the row.
    // single request
    setv(0,  0, 4'b0001, 4'b0000, 0);
    setv(1,  0, 4'b0001, 4'b0001, 0);
    setv(2,  0, 4'b0001, 4'b0000, 0);
    setv(3,  0, 4'b0000, 4'b0000, 0);
    setv(4,  1, 4'b0000, 4'b0000, 0);
    // all four simultaneous from ptr=0
    setv(5,  0, 4'b1111, 4'b0000, 0);
    setv(6,  0, 4'b1111, 4'b0001, 0);
    setv(7,  0, 4'b1111, 4'b0010, 1);
    setv(8,  0, 4'b1110, 4'b0100, 2);
    setv(9,  0, 4'b1100, 4'b1000, 3);
    setv(10, 0, 4'b1000, 4'b0000, 0);
    setv(11, 0, 4'b0000, 4'b0000, 0);
    // greedy master 0
    setv(12, 0, 4'b1111, 4'b0000, 0);
    setv(13, 0, 4'b1111, 4'b0001, 0);
    setv(14, 0, 4'b1111, 4'b0010, 1);
    setv(15, 0, 4'b1111, 4'b0100, 2);
    setv(16, 0, 4'b1101, 4'b1000, 3);
    setv(17, 0, 4'b1001, 4'b0001, 0);
    setv(18, 0, 4'b0001, 4'b0000, 0);
    setv(19, 0, 4'b0000, 4'b0000, 0);
    // withdrawal of master 2 behind master 1 (ptr=1)
    setv(20, 0, 4'b0110, 4'b0000, 0);
    setv(21, 0, 4'b0010, 4'b0010, 1);
    setv(22, 0, 4'b0010, 4'b0000, 0);
    setv(23, 0, 4'b0000, 4'b0000, 0);
    // reset mid-queue (ptr=2)
    setv(24, 0, 4'b1111, 4'b0000, 0);
    setv(25, 0, 4'b1111, 4'b0100, 2);
    setv(26, 0, 4'b1111, 4'b1000, 3);
    setv(27, 1, 4'b1111, 4'b0000, 0);
    setv(28, 0, 4'b1111, 4'b0000, 0);
    setv(29, 0, 4'b1111, 4'b0001, 0);
    setv(30, 0, 4'b0000, 4'b0010, 1);
    setv(31, 0, 4'b0000, 4'b0000, 0);

    rst = 1'b1;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_vld", 32'(gnt_vld), 0);
    chk("reset_id", 32'(gnt_id), 0);
    chk("reset_lat_err", 32'(lat_err), 0);

    for (int unsigned k = 0; k < NV; k++) begin
      @(negedge clk);
      rst = vecs[k].rst;
      req = vecs[k].req;
      sb.push_back('{idx: k, gnt: vecs[k].gnt, id: vecs[k].id});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d_gnt", e.idx), 32'(gnt), 32'(e.gnt));
      chk($sformatf("vec%0d_id", e.idx), 32'(gnt_id), 32'(e.id));
      chk($sformatf("vec%0d_vld", e.idx), 32'(gnt_vld), 32'(|e.gnt));
      chk($sformatf("vec%0d_lat_err", e.idx), 32'(lat_err), 0);
    end

    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      age[i]   = 0;
      outst[i] = 1'b0;
      hold[i]  = 1'b0;
    end

    // Masters obey the protocol: hold req through the grant edge, then drop or re-request.
    for (int unsigned cyc = 0; cyc < NRND + 12; cyc++) begin
      @(negedge clk);
      g = gnt;
      chk("gnt_format", {28'd0, gnt_vld, gnt_id, $onehot0(g)}, {28'd0, |g, enc(g), 1'b1});
      for (int unsigned i = 0; i < N; i++) begin
        if (hold[i]) begin
          chk($sformatf("gnt_pulse_m%0d", i), 32'(g[i]), 0);
          hold[i] = 1'b0;
          if (cyc < NRND && $urandom_range(1) == 1) begin
            req[i]   = 1'b1;
            outst[i] = 1'b1;
            age[i]   = 0;
          end else begin
            req[i] = 1'b0;
          end
        end else if (outst[i]) begin
          age[i]++;
          if (g[i]) begin
            chk($sformatf("latency_m%0d_age%0d", i, age[i]),
                32'(age[i] >= 2 && age[i] <= WMAX), 1);
            outst[i] = 1'b0;
            hold[i]  = 1'b1;
          end else if (age[i] > WMAX) begin
            chk($sformatf("grant_timeout_m%0d", i), age[i], WMAX);
            outst[i] = 1'b0;
            req[i]   = 1'b0;
          end
        end else begin
          chk($sformatf("no_spurious_gnt_m%0d", i), 32'(g[i]), 0);
          if (cyc < NRND && $urandom_range(2) == 0) begin
            req[i]   = 1'b1;
            outst[i] = 1'b1;
            age[i]   = 0;
          end
        end
      end
    end

    for (int unsigned i = 0; i < N; i++) begin
      chk($sformatf("drained_m%0d", i), 32'(outst[i]), 0);
    end
    chk("random_lat_err", 32'(lat_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
